// File: rtl/pid_step_sequencer.sv
// pid_step_sequencer: one PID altitude update per control tick on a single shared multiplier,
// followed by gravity, clamping to [Y_MIN, Y_MAX] and an error-history shift.
module pid_step_sequencer #(
    parameter int KP       = 8,
    parameter int KI       = 27,
    parameter int KD       = 3,
    parameter int GRAV     = 3,
    parameter int Y_MIN    = 5,
    parameter int Y_MAX    = 450,
    parameter int TICK_DIV = 10_000_000
) (
    input  logic               CLK,
    input  logic               RST_BTN,
    input  logic               heli_go,
    input  logic               gravity,
    input  logic signed [14:0] setpoint,
    output logic signed [14:0] y_out,
    output logic signed [14:0] err_out,
    output logic               busy,
    output logic               step_done,
    output logic               overrun
);
    localparam logic signed [7:0] K1 = 8'(KI + KD - KP);
    localparam logic signed [7:0] K2 = 8'(KP - 2 * KD);
    localparam logic signed [7:0] K3 = 8'(KD);

    typedef enum logic [2:0] {IDLE, SAMPLE, MAC0, MAC1, MAC2, UPDATE} state_t;

    state_t             r_state, w_next;
    logic [26:0]        r_cnt;
    logic               r_go, r_grav, r_busy, r_done, r_ovr;
    logic signed [14:0] r_y, r_err, r_e1, r_e2;
    logic signed [23:0] r_acc;
    logic               w_tick;
    logic signed [14:0] w_op_a, w_err, w_clamp;
    logic signed [7:0]  w_op_b;
    logic signed [23:0] w_prod, w_quot, w_cand;

    assign w_tick = r_cnt == 27'(TICK_DIV - 1);
    assign w_op_a = r_state == MAC1 ? r_e1 : r_state == MAC2 ? r_e2 : r_err;
    assign w_op_b = r_state == MAC1 ? K2 : r_state == MAC2 ? K3 : K1;
    assign w_prod = 24'(w_op_a) * 24'(w_op_b);
    // Division (not >>>) so negative products truncate toward zero
    assign w_quot = w_prod / 24'sd16;
    assign w_err  = setpoint - r_y - 15'sd10;
    // acc stays zero on gravity-only steps, so the same clamp serves both paths
    assign w_cand = 24'(r_y) + r_acc + (r_grav ? 24'(GRAV) : 24'sd0);
    assign w_clamp = w_cand < 24'(Y_MIN) ? 15'(Y_MIN) :
                     w_cand > 24'(Y_MAX) ? 15'(Y_MAX) : w_cand[14:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_tick ? SAMPLE : IDLE;
            SAMPLE:  w_next = heli_go ? MAC0 : UPDATE;
            MAC0:    w_next = MAC1;
            MAC1:    w_next = MAC2;
            MAC2:    w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_go    <= 1'b0;
            r_grav  <= 1'b0;
            r_y     <= 15'(Y_MAX);
            r_err   <= '0;
            r_e1    <= '0;
            r_e2    <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_tick ? 27'd0 : r_cnt + 27'd1;
            r_busy  <= w_next != IDLE;
            r_done  <= r_state == UPDATE;
            r_ovr   <= w_tick && r_state != IDLE;
            case (r_state)
                SAMPLE: begin
                    r_go   <= heli_go;
                    r_grav <= gravity;
                    r_err  <= w_err;
                    r_acc  <= '0;
                end
                MAC0:   r_acc <= r_acc + w_quot;
                MAC1:   r_acc <= r_acc - w_quot;
                MAC2:   r_acc <= r_acc + w_quot;
                UPDATE: begin
                    r_y <= w_clamp;
                    if (r_go) begin
                        r_e2 <= r_e1;
                        r_e1 <= r_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_out     = r_y;
    assign err_out   = r_err;
    assign busy      = r_busy;
    assign step_done = r_done;
    assign overrun   = r_ovr;
endmodule

// File: tb/tb_pid_step_sequencer.sv
// tb_pid_step_sequencer: randomized steps checked against an integer PID model,
// plus directed reset, clamp, gravity and overrun scenarios.
module tb_pid_step_sequencer;
    localparam int TD = 16;

    logic CLK = 1'b0;
    logic RST_BTN = 1'b0;
    logic heli_go, gravity;
    logic signed [14:0] setpoint;
    logic signed [14:0] y_out, err_out, y2, err2;
    logic busy, step_done, overrun, busy2, done2, ovr2;

    int total = 0;
    int bad = 0;
    int my, me1, me2, merr;
    int ovr_main = 0;

    pid_step_sequencer #(.TICK_DIV(TD)) dut (
        .CLK(CLK), .RST_BTN(RST_BTN), .heli_go(heli_go), .gravity(gravity),
        .setpoint(setpoint), .y_out(y_out), .err_out(err_out), .busy(busy),
        .step_done(step_done), .overrun(overrun)
    );

    pid_step_sequencer #(.TICK_DIV(4)) dut_ovr (
        .CLK(CLK), .RST_BTN(RST_BTN), .heli_go(heli_go), .gravity(gravity),
        .setpoint(setpoint), .y_out(y2), .err_out(err2), .busy(busy2),
        .step_done(done2), .overrun(ovr2)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (RST_BTN && overrun) ovr_main++;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        my = 450;
        me1 = 0;
        me2 = 0;
        merr = 0;
    endtask

    task automatic model_step(input bit go, input bit grav, input int sp);
        int cand;
        merr = sp - my - 10;
        if (go) begin
            cand = my + (22 * merr) / 16 - (2 * me1) / 16 + (3 * me2) / 16 + (grav ? 3 : 0);
            me2 = me1;
            me1 = merr;
        end else
            cand = my + (grav ? 3 : 0);
        my = cand < 5 ? 5 : cand > 450 ? 450 : cand;
    endtask

    task automatic apply_reset();
        RST_BTN = 1'b0;
        repeat (2) @(negedge CLK);
        RST_BTN = 1'b1;
        model_reset();
    endtask

    task automatic do_step(input bit go, input bit grav, input int sp, input string tag);
        int n = 0;
        int b_at = -1;
        int d_at = -1;
        int busy_at_done = 1;
        heli_go = go;
        gravity = grav;
        setpoint = 15'(sp);
        model_step(go, grav, sp);
        while (d_at < 0 && n < 3 * TD + 20) begin
            @(negedge CLK);
            n++;
            if (busy && b_at < 0) b_at = n;
            // inputs after SAMPLE must not influence this step
            if (b_at >= 0 && n == b_at + 1) begin
                heli_go = 1'($urandom);
                gravity = 1'($urandom);
                setpoint = 15'($urandom_range(0, 479));
            end
            if (step_done) begin
                d_at = n;
                busy_at_done = int'(busy);
            end
        end
        chk({tag, "_seen"}, int'(d_at >= 0 && b_at >= 0), 1);
        chk({tag, "_lat"}, d_at - b_at, go ? 5 : 2);
        chk({tag, "_busy_end"}, busy_at_done, 0);
        chk({tag, "_err"}, int'(err_out), merr);
        chk({tag, "_y"}, int'(y_out), my);
    endtask

    initial begin
        int n, cnt, gap;
        heli_go = 1'b1;
        gravity = 1'b0;
        setpoint = 15'sd240;
        repeat (3) @(negedge CLK);
        chk("rst_y", int'(y_out), 450);
        chk("rst_err", int'(err_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(step_done), 0);
        chk("rst_ovr", int'(overrun), 0);
        RST_BTN = 1'b1;

        n = 0;
        while (!done2 && n < 40) begin @(negedge CLK); n++; end
        chk("ovr_first_y", int'(y2), 148);
        cnt = 0;
        gap = 0;
        do begin
            @(negedge CLK);
            gap++;
            if (ovr2) cnt++;
        end while (!done2 && gap < 40);
        chk("ovr_pulses", cnt, 1);
        chk("ovr_gap", gap, 8);
        chk("ovr_second_y", int'(y2), 287);

        apply_reset();
        do_step(1, 0, 240, "pid1");
        do_step(1, 0, 240, "pid2");

        heli_go = 1'b1;
        gravity = 1'b0;
        setpoint = 15'sd240;
        n = 0;
        while (!busy && n < 3 * TD) begin @(negedge CLK); n++; end
        repeat (2) @(negedge CLK);
        RST_BTN = 1'b0;
        #1;
        chk("midrst_y", int'(y_out), 450);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err", int'(err_out), 0);
        @(negedge CLK);
        RST_BTN = 1'b1;
        model_reset();
        cnt = 0;
        repeat (10) begin @(negedge CLK); if (step_done) cnt++; end
        chk("midrst_no_done", cnt, 0);
        do_step(1, 1, 240, "pid_grav");

        apply_reset();
        do_step(1, 0, 1, "clamp_lo");
        while (my < 449) do_step(0, 1, int'($urandom_range(0, 479)), "grav_only");
        do_step(0, 1, 300, "grav_top");
        do_step(0, 0, 300, "hold");

        for (int i = 0; i < 60; i++)
            do_step(1'($urandom), 1'($urandom), int'($urandom_range(0, 479)), "rand");

        chk("main_no_overrun", ovr_main, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
